instr_encoder: RTL

Packs decoded instruction fields (rd, rs1, rs2, immed, func, joffset, ctrl) back into 32-bit RV32 instruction words, the exact inverse of the core's field decoder. It buffers encoded words in a small FIFO and streams them, tagged with a sequential program address, to the instruction-memory loader. Illegal ctrl patterns are dropped and counted. The block is used by the test/loader path to build programs in hardware from field bundles.

---
 rtl/instr_encoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs decoded RV32 instruction fields back into 32-bit words and streams them,
// tagged with a running program address, through a small circular FIFO.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] immed,
    input  logic [9:0]  func,
    input  logic [19:0] joffset,
    input  logic [6:0]  ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int AW = $clog2(DEPTH);

    // ctrl bit order: {auipc, branch, jump, immediate, memRead, memWrite, regWrite}
    localparam logic [6:0] CTRL_R     = 7'b0000001;
    localparam logic [6:0] CTRL_I     = 7'b0001001;
    localparam logic [6:0] CTRL_AUIPC = 7'b1001001;
    localparam logic [6:0] CTRL_S     = 7'b0001010;
    localparam logic [6:0] CTRL_B     = 7'b0101000;
    localparam logic [6:0] CTRL_J     = 7'b0010000;
    localparam logic [6:0] CTRL_L     = 7'b0001101;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_L     = 7'b0000011;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] pc;

    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic        legal;
    logic [31:0] word;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign f3 = func[2:0];
    assign f7 = func[9:3];

    // B and J immediates arrive already scrambled the way the decoder emits them,
    // so re-encoding is a pure bit permutation with no shifting.
    always_comb begin
        legal = 1'b1;
        word  = '0;
        unique case (ctrl)
            CTRL_R:     word = {f7, rs2, rs1, f3, rd, OP_R};
            CTRL_I:     word = {immed, rs1, f3, rd, OP_I};
            CTRL_AUIPC: word = {joffset, rd, OP_AUIPC};
            CTRL_S:     word = {immed[11:5], rs2, rs1, f3, immed[4:0], OP_S};
            CTRL_B:     word = {immed[11], immed[9:4], rs2, rs1, f3,
                                immed[3:0], immed[10], OP_B};
            CTRL_J:     word = {joffset[19], joffset[9:0], joffset[10],
                                joffset[18:11], rd, OP_J};
            CTRL_L:     word = {immed, rs1, f3, rd, OP_L};
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    assign instr_out = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
    assign pc_out    = pc;

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && !restart && push) begin
            mem[wr_ptr[AW-1:0]] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pc      <= BASE_ADDR;
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (restart) begin
            // The error history survives a restart; only the stream is flushed.
            wr_ptr <= '0;
            rd_ptr <= '0;
            pc     <= BASE_ADDR;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                pc     <= pc + 32'd4;
            end
            err <= accept && !legal;
            if (accept && !legal && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
